hazard_forward_unit: RTL
========================

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register-address width.
REQ-002 SHALL have clk_i, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have rst_i, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have id_valid_i, input, 1, a decoded instruction is present in ID.
REQ-005 SHALL have id_rs_i / id_rt_i, input, ADDR_W each, the ID source registers.
REQ-006 SHALL have id_rd_i, input, ADDR_W, the ID destination register.
REQ-007 SHALL have id_regwrite_i / id_memread_i, input, 1 each, the ID control bits.
REQ-008 SHALL have flush_i, input, 1, branch taken; squash the ID instruction.
REQ-009 SHALL have fwd_a_o / fwd_b_o, output, 2 each, select for the EX operand A/B 3-input muxes.
REQ-010 SHALL have stall_o, output, 1, load-use stall; hold PC and IF/ID.
REQ-011 SHALL have pc_write_o / ifid_write_o, output, 1 each, equal to ~stall_o.

Function
REQ-012 SHALL keep three shadow slots EX{valid,rs,rt,rd,regwrite,memread}, MEM{valid,rd,regwrite} and WB{valid,rd,regwrite}, advancing ID->EX->MEM->WB every cycle.
REQ-013 SHALL use select encoding 0=ID/EX register operand, 1=EX/MEM ALU result, 2=MEM/WB write-back data; 3 SHALL never be driven.
REQ-014 SHALL drive fwd_a_o=1 when MEM.valid & MEM.regwrite & MEM.rd!=0 & MEM.rd==EX.rs.
REQ-015 Otherwise SHALL drive fwd_a_o=2 when the same test holds for the WB slot; else 0. EX/MEM has priority when both match.
REQ-016 SHALL derive fwd_b_o identically using EX.rt.
REQ-017 SHALL derive fwd outputs combinationally from slot registers only, with zero-cycle latency relative to EX-slot contents.
REQ-018 SHALL assert stall_o when id_valid_i & EX.valid & EX.memread & EX.rd!=0 & (EX.rd==id_rs_i | EX.rd==id_rt_i).
REQ-019 On a stall cycle, SHALL load a bubble (all fields 0) into EX, while MEM and WB advance normally.
REQ-020 On flush_i, SHALL load a bubble into EX and deassert stall_o. Flush wins over stall.
REQ-021 SHALL treat id_valid_i=0 as a bubble, with no stall.
REQ-022 SHALL never forward or stall on register 0.
REQ-023 Back-to-back loads: the second stall evaluation SHALL see only the bubble, so a stall lasts exactly one cycle per load-use pair.

Reset
REQ-024 While rst_i=1 at a clock edge, SHALL clear all slot fields to 0.
REQ-025 In the cycle after reset, fwd_a_o=0, fwd_b_o=0, stall_o=0, and pc_write_o=ifid_write_o=1.
REQ-026 Reset asserted mid-stall SHALL override it; no bubble or stall carries over.

Configuration
REQ-027 With macro HAZARD_FWD_EN defined, SHALL behave per REQ-014..REQ-018.
REQ-028 With HAZARD_FWD_EN undefined, fwd_a_o/fwd_b_o SHALL be constant 0.
REQ-029 With HAZARD_FWD_EN undefined, stall_o SHALL assert on any nonzero source match against a valid regwrite EX or MEM slot; the register file writes before reading, so WB needs no stall.

Structure
REQ-030 SHALL take FWD_REG=2'd0, FWD_EXMEM=2'd1, FWD_MEMWB=2'd2 and the slot field layout from shared package hazard_pkg.
REQ-031 SHALL instantiate sub-module hazard_slot, a reset/bubble-loadable slot register, once per stage.

Verification
REQ-032 add $3,$1,$2 then sub $4,$3,$5 -> cycle sub is in EX: fwd_a_o=1, fwd_b_o=0.
REQ-033 add $3 / nop / or $6,$5,$3 -> fwd_b_o=2. With add $3 / add $3 / or $6,$3,$3 -> fwd_a_o=fwd_b_o=1 (priority).
REQ-034 lw $2,0($1) then add $4,$2,$2 -> stall_o=1 for exactly one cycle; EX bubble; next cycle fwd_a_o=fwd_b_o=2.
REQ-035 lw $2 in EX with a matching ID instruction and flush_i=1 -> stall_o=0, EX bubble, no forward next cycle.
REQ-036 add $0,$1,$1 then add $5,$0,$0 -> fwd outputs 0. rst_i pulse during a stall -> all outputs at reset values next cycle.
REQ-037 HAZARD_FWD_EN undefined, add $3 then sub $4,$3,$5 -> stall_o=1 for two cycles, fwd outputs 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared select encodings, slot control-field layouts and the forward priority helper
// used by the hazard/forwarding unit.
package hazard_pkg;

  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  // Control bits carried by the EX slot; packed above {rs, rt, rd}.
  typedef struct packed {
    logic valid;
    logic regwrite;
    logic memread;
  } ex_ctrl_t;

  // Control bits carried by the MEM and WB slots; packed above {rd}.
  typedef struct packed {
    logic valid;
    logic regwrite;
  } wb_ctrl_t;

  localparam int unsigned EX_CTRL_W = $bits(ex_ctrl_t);
  localparam int unsigned WB_CTRL_W = $bits(wb_ctrl_t);

  function automatic int unsigned ex_slot_w(input int unsigned addr_w);
    return EX_CTRL_W + 3 * addr_w;
  endfunction

  function automatic int unsigned wb_slot_w(input int unsigned addr_w);
    return WB_CTRL_W + addr_w;
  endfunction

  // The younger producer (EX/MEM) wins over the older one (MEM/WB).
  function automatic logic [1:0] fwd_select(input logic exmem_hit, input logic memwb_hit);
    if (exmem_hit) return FWD_EXMEM;
    if (memwb_hit) return FWD_MEMWB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_slot.sv
// One pipeline shadow slot: loads d_i each cycle, or all zeros on reset or bubble.
module hazard_slot #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             bubble_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i || bubble_i) q_o <= '0;
    else                   q_o <= d_i;
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand-forwarding select and load-use stall generation for a 5-stage pipeline.
// Define HAZARD_FWD_EN for forwarding; otherwise fwd outputs are 0 and RAW hazards stall.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [ADDR_W-1:0] id_rs_i,
  input  logic [ADDR_W-1:0] id_rt_i,
  input  logic [ADDR_W-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              stall_o,
  output logic              pc_write_o,
  output logic              ifid_write_o
);

  localparam int unsigned EX_W = ex_slot_w(ADDR_W);
  localparam int unsigned MW_W = wb_slot_w(ADDR_W);

  logic [EX_W-1:0]   ex_d, ex_q;
  logic [MW_W-1:0]   mem_d, mem_q, wb_q;
  logic              ex_bubble_c;
  logic              stall_raw_c;

  ex_ctrl_t          id_ctrl, ex_ctrl;
  wb_ctrl_t          mem_in_ctrl, mem_ctrl, wb_ctrl;
  logic [ADDR_W-1:0] ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;

  // True when a slot will write a nonzero register equal to src.
  function automatic logic src_hit(input logic              valid,
                                   input logic              regwrite,
                                   input logic [ADDR_W-1:0] rd,
                                   input logic [ADDR_W-1:0] src);
    return valid & regwrite & (rd != '0) & (rd == src);
  endfunction

  assign {ex_ctrl, ex_rs, ex_rt, ex_rd} = ex_q;
  assign {mem_ctrl, mem_rd}             = mem_q;
  assign {wb_ctrl, wb_rd}               = wb_q;

  // An invalid ID instruction enters EX as an all-zero bubble.
  always_comb begin
    id_ctrl          = '0;
    id_ctrl.valid    = 1'b1;
    id_ctrl.regwrite = id_regwrite_i;
    id_ctrl.memread  = id_memread_i;
    ex_d             = '0;
    if (id_valid_i) ex_d = {id_ctrl, id_rs_i, id_rt_i, id_rd_i};
  end

  always_comb begin
    mem_in_ctrl          = '0;
    mem_in_ctrl.valid    = ex_ctrl.valid;
    mem_in_ctrl.regwrite = ex_ctrl.regwrite;
    mem_d                = {mem_in_ctrl, ex_rd};
  end

  assign ex_bubble_c = stall_raw_c | flush_i;

  hazard_slot #(.WIDTH(EX_W)) u_ex_slot (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .bubble_i (ex_bubble_c),
    .d_i      (ex_d),
    .q_o      (ex_q)
  );

  hazard_slot #(.WIDTH(MW_W)) u_mem_slot (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .bubble_i (1'b0),
    .d_i      (mem_d),
    .q_o      (mem_q)
  );

  hazard_slot #(.WIDTH(MW_W)) u_wb_slot (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .bubble_i (1'b0),
    .d_i      (mem_q),
    .q_o      (wb_q)
  );

`ifdef HAZARD_FWD_EN
  // Forward selects come straight from slot contents; only loads in EX stall.
  always_comb begin
    fwd_a_o     = fwd_select(src_hit(mem_ctrl.valid, mem_ctrl.regwrite, mem_rd, ex_rs),
                             src_hit(wb_ctrl.valid,  wb_ctrl.regwrite,  wb_rd,  ex_rs));
    fwd_b_o     = fwd_select(src_hit(mem_ctrl.valid, mem_ctrl.regwrite, mem_rd, ex_rt),
                             src_hit(wb_ctrl.valid,  wb_ctrl.regwrite,  wb_rd,  ex_rt));
    stall_raw_c = id_valid_i & ex_ctrl.valid & ex_ctrl.memread & (ex_rd != '0) &
                  ((ex_rd == id_rs_i) | (ex_rd == id_rt_i));
  end
`else
  logic unused_slot_bits;

  // Without bypass paths, wait until the producer reaches WB (write-before-read).
  always_comb begin
    fwd_a_o     = FWD_REG;
    fwd_b_o     = FWD_REG;
    stall_raw_c = id_valid_i &
                  (src_hit(ex_ctrl.valid,  ex_ctrl.regwrite,  ex_rd,  id_rs_i) |
                   src_hit(ex_ctrl.valid,  ex_ctrl.regwrite,  ex_rd,  id_rt_i) |
                   src_hit(mem_ctrl.valid, mem_ctrl.regwrite, mem_rd, id_rs_i) |
                   src_hit(mem_ctrl.valid, mem_ctrl.regwrite, mem_rd, id_rt_i));
  end

  assign unused_slot_bits = ^{wb_ctrl, wb_rd, ex_rs, ex_rt, ex_ctrl.memread};
`endif

  // A taken branch squashes ID, so it never needs to be held.
  assign stall_o      = stall_raw_c & ~flush_i;
  assign pc_write_o   = ~stall_o;
  assign ifid_write_o = ~stall_o;

endmodule
